// File: rtl/smac_ctrl_pkg.sv
// Shared types and geometry for the serial-MAC controller: job loop bounds,
// FSM encoding and the per-beat tag that travels down the strobe pipeline.
package smac_ctrl_pkg;

    localparam int M      = 16;
    localparam int PA     = 8;
    localparam int PW     = 4;
    localparam int MNO    = 288;
    localparam int NCHUNK = MNO / M;
    localparam int NLANE  = 4;
    localparam int PIPE_D = 6;

    localparam int KW = $clog2(PA);
    localparam int JW = $clog2(PW);
    localparam int CW = $clog2(NCHUNK);
    localparam int LW = 2;

    localparam logic [KW-1:0] K_LAST = KW'(PA - 1);
    localparam logic [JW-1:0] J_LAST = JW'(PW - 1);
    localparam logic [LW-1:0] L_LAST = LW'(NLANE - 1);
    localparam logic [CW-1:0] C_LAST = CW'(NCHUNK - 1);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        OUT
    } state_t;

    typedef struct packed {
        logic [KW-1:0] k;
        logic [JW-1:0] j;
        logic [LW-1:0] l;
        logic [CW-1:0] c;
        logic          vld;
    } tag_t;

endpackage

// File: rtl/s_mac_ctrl_pipe.sv
// Tag delay line: tap[i] holds the tag of the beat accepted i+1 cycles ago.
// Always advances; flush or reset empties every stage so no stale strobe fires.
module s_mac_ctrl_pipe
    import smac_ctrl_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  tag_t                  tag_in,
    output tag_t [PIPE_D-1:0]     tap
);

    tag_t [PIPE_D-1:0] sr_q;
    tag_t [PIPE_D-1:0] sr_d;

    always_comb begin
        sr_d    = sr_q;
        sr_d[0] = tag_in;
        for (int i = 1; i < PIPE_D; i++) begin
            sr_d[i] = sr_q[i-1];
        end
        if (flush) begin
            sr_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign tap = sr_q;

endmodule

// File: rtl/s_mac_ctrl.sv
// Serial-MAC sequencer: accepts bit-serial beats while FEED, decodes delayed tags into
// batch 0-3 strobes, then presents 4 output lanes. Beats are refused outside FEED.
module s_mac_ctrl
    import smac_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       busy,
    output logic       done,
    output logic       out_valid,
    output logic       proto_err,
    output logic       cl_en_gen,
    output logic       w_en_a,
    output logic       w_en_w,
    output logic       w_en_br,
    output logic       MSB_a,
    output logic       cl_en_ac1,
    output logic       w_and_s_ac1,
    output logic       MSB_w,
    output logic       w_en_neg,
    output logic       cl_en_ac2,
    output logic       valid_ac2,
    output logic [1:0] sel_ac2,
    output logic       cl_en_ac3,
    output logic       valid_ac3,
    output logic       s_en_ac3,
    output logic [1:0] sel_ac3,
    output logic [1:0] sel_mux_relu
);

    state_t          state_q, state_d;
    logic [KW-1:0]   k_q, k_d;
    logic [JW-1:0]   j_q, j_d;
    logic [LW-1:0]   l_q, l_d;
    logic [CW-1:0]   c_q, c_d;
    logic [1:0]      ocnt_q, ocnt_d;

    tag_t              tag_in;
    tag_t [PIPE_D-1:0] tap;
    logic              accept, perr, last_beat, ac3_hit, last_ac3;
    logic              unused_tap;

    assign accept    = (state_q == FEED) && in_valid && !rst;
    assign perr      = (state_q == FEED) && !in_valid && (k_q != '0);
    assign last_beat = (k_q == K_LAST) && (j_q == J_LAST) && (l_q == L_LAST) && (c_q == C_LAST);
    // tap[4] is T+5: the ac3 write of a word whose last weight bit just finished
    assign ac3_hit   = tap[4].vld && (tap[4].k == K_LAST) && (tap[4].j == J_LAST);
    assign last_ac3  = ac3_hit && (tap[4].l == L_LAST) && (tap[4].c == C_LAST);
    assign unused_tap = ^tap;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= '0;
            j_q     <= '0;
            l_q     <= '0;
            c_q     <= '0;
            ocnt_q  <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            j_q     <= j_d;
            l_q     <= l_d;
            c_q     <= c_d;
            ocnt_q  <= ocnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CLEAR;
            CLEAR:   state_d = FEED;
            FEED: begin
                if (perr) begin
                    state_d = IDLE;
                end else if (accept && last_beat) begin
                    state_d = DRAIN;
                end
            end
            DRAIN:   if (last_ac3) state_d = OUT;
            OUT:     if (ocnt_q == 2'd3) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        k_d    = k_q;
        j_d    = j_q;
        l_d    = l_q;
        c_d    = c_q;
        ocnt_d = (state_q == OUT) ? ocnt_q + 2'd1 : 2'd0;
        if (state_q == CLEAR || perr) begin
            k_d = '0;
            j_d = '0;
            l_d = '0;
            c_d = '0;
        end else if (accept) begin
            if (k_q == K_LAST) begin
                k_d = '0;
                if (j_q == J_LAST) begin
                    j_d = '0;
                    if (l_q == L_LAST) begin
                        l_d = '0;
                        c_d = c_q + CW'(1);
                    end else begin
                        l_d = l_q + LW'(1);
                    end
                end else begin
                    j_d = j_q + JW'(1);
                end
            end else begin
                k_d = k_q + KW'(1);
            end
        end
    end

    always_comb begin
        tag_in = '0;
        if (accept) begin
            tag_in.k   = k_q;
            tag_in.j   = j_q;
            tag_in.l   = l_q;
            tag_in.c   = c_q;
            tag_in.vld = 1'b1;
        end
    end

    s_mac_ctrl_pipe u_pipe (
        .clk    (clk),
        .rst    (rst),
        .flush  (perr),
        .tag_in (tag_in),
        .tap    (tap)
    );

    // Outputs are forced low during reset so nothing downstream sees a stale strobe.
    always_comb begin
        in_ready     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        out_valid    = 1'b0;
        proto_err    = 1'b0;
        cl_en_gen    = 1'b0;
        w_en_a       = 1'b0;
        w_en_w       = 1'b0;
        w_en_br      = 1'b0;
        MSB_a        = 1'b0;
        cl_en_ac1    = 1'b0;
        w_and_s_ac1  = 1'b0;
        MSB_w        = 1'b0;
        w_en_neg     = 1'b0;
        cl_en_ac2    = 1'b0;
        valid_ac2    = 1'b0;
        sel_ac2      = 2'd0;
        cl_en_ac3    = 1'b0;
        valid_ac3    = 1'b0;
        s_en_ac3     = 1'b0;
        sel_ac3      = 2'd0;
        sel_mux_relu = 2'd0;
        if (!rst) begin
            in_ready    = (state_q == FEED);
            busy        = (state_q != IDLE);
            proto_err   = perr;
            cl_en_gen   = (state_q == CLEAR);
            w_en_a      = accept;
            w_en_w      = accept;
            w_en_br     = tap[0].vld;
            MSB_a       = tap[0].vld && (tap[0].k == '0);
            cl_en_ac1   = (state_q == CLEAR) || tap[1].vld;
            w_and_s_ac1 = tap[1].vld && (tap[1].k != '0);
            w_en_neg    = tap[2].vld && (tap[2].k == K_LAST);
            MSB_w       = w_en_neg && (tap[2].j == '0);
            valid_ac2   = tap[3].vld && (tap[3].k == K_LAST);
            sel_ac2     = valid_ac2 ? tap[3].l : 2'd0;
            valid_ac3   = ac3_hit;
            sel_ac3     = ac3_hit ? tap[4].l : 2'd0;
            s_en_ac3    = ac3_hit && (tap[4].c != '0);
            cl_en_ac3   = (state_q == CLEAR);
            cl_en_ac2   = (state_q == CLEAR) ||
                          (tap[5].vld && (tap[5].k == K_LAST) &&
                           (tap[5].j == J_LAST) && (tap[5].l == L_LAST));
            out_valid    = (state_q == OUT);
            sel_mux_relu = out_valid ? ocnt_q : 2'd0;
            done         = out_valid && (ocnt_q == 2'd3);
        end
    end

endmodule

// File: tb/tb_s_mac_ctrl.sv
// Bench for s_mac_ctrl: short reset/CLEAR vector table, then full jobs checked every
// cycle against a beat-tag scoreboard plus job-level timing and count checks.
module tb_s_mac_ctrl;
    import smac_ctrl_pkg::*;

    logic clk = 1'b0;
    logic rst, start, in_valid;
    logic in_ready, busy, done, out_valid, proto_err;
    logic cl_en_gen, w_en_a, w_en_w, w_en_br, MSB_a;
    logic cl_en_ac1, w_and_s_ac1, MSB_w, w_en_neg;
    logic cl_en_ac2, valid_ac2, cl_en_ac3, valid_ac3, s_en_ac3;
    logic [1:0] sel_ac2, sel_ac3, sel_mux_relu;

    always #5 clk = ~clk;

    s_mac_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_ready(in_ready), .busy(busy), .done(done), .out_valid(out_valid),
        .proto_err(proto_err), .cl_en_gen(cl_en_gen), .w_en_a(w_en_a),
        .w_en_w(w_en_w), .w_en_br(w_en_br), .MSB_a(MSB_a), .cl_en_ac1(cl_en_ac1),
        .w_and_s_ac1(w_and_s_ac1), .MSB_w(MSB_w), .w_en_neg(w_en_neg),
        .cl_en_ac2(cl_en_ac2), .valid_ac2(valid_ac2), .sel_ac2(sel_ac2),
        .cl_en_ac3(cl_en_ac3), .valid_ac3(valid_ac3), .s_en_ac3(s_en_ac3),
        .sel_ac3(sel_ac3), .sel_mux_relu(sel_mux_relu)
    );

    typedef struct {
        logic       rst;
        logic       start;
        logic       iv;
        logic [7:0] exp;   // {busy,in_ready,w_en_a,cl_en_gen,w_en_br,MSB_a,cl_en_ac1,w_and_s_ac1}
    } vec_t;

    typedef struct {
        int t;
        int k;
        int j;
        int l;
        int c;
    } ev_t;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    state_t ms;
    int mk, mj, ml, mc, mo;
    ev_t q[$];
    bit word_done;

    int nacc, dut_ac3, dut_done, dut_perr;
    int first_wen, last_wen, first_ov, done_cyc;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic check_and_model();
        logic [24:0] exp, act;
        bit rdy, acc, perr, clr, br, msba, ac1, was, neg, msbw, ac2v, ac3v, sen, clac2, ov, dn, lastac3, last;
        logic [1:0] s2, s3, sm;
        rdy = (ms == FEED);
        acc = rdy && in_valid && !rst;
        perr = (ms == FEED) && !in_valid && (mk != 0);
        clr = (ms == CLEAR);
        {br, msba, ac1, was, neg, msbw, ac2v, ac3v, sen, clac2, lastac3} = '0;
        s2 = 2'd0;
        s3 = 2'd0;
        foreach (q[i]) begin
            int d;
            d = cyc - q[i].t;
            if (d == 1) begin br = 1; if (q[i].k == 0) msba = 1; end
            if (d == 2) begin ac1 = 1; if (q[i].k != 0) was = 1; end
            if (q[i].k == PA - 1) begin
                if (d == 3) begin neg = 1; if (q[i].j == 0) msbw = 1; end
                if (d == 4) begin ac2v = 1; s2 = 2'(q[i].l); end
                if (q[i].j == PW - 1) begin
                    if (d == 5) begin
                        ac3v = 1;
                        s3 = 2'(q[i].l);
                        sen = (q[i].c != 0);
                        if (q[i].l == 3 && q[i].c == NCHUNK - 1) lastac3 = 1;
                    end
                    if (d == 6 && q[i].l == 3) clac2 = 1;
                end
            end
        end
        ov = (ms == OUT);
        sm = ov ? 2'(mo) : 2'd0;
        dn = ov && (mo == 3);
        exp = {rdy, (ms != IDLE), dn, ov, perr, clr, acc, acc, br, msba, clr | ac1, was,
               msbw, neg, clr | clac2, ac2v, s2, clr, ac3v, sen, s3, sm};
        if (rst) exp = '0;
        act = {in_ready, busy, done, out_valid, proto_err, cl_en_gen, w_en_a, w_en_w, w_en_br,
               MSB_a, cl_en_ac1, w_and_s_ac1, MSB_w, w_en_neg, cl_en_ac2, valid_ac2, sel_ac2,
               cl_en_ac3, valid_ac3, s_en_ac3, sel_ac3, sel_mux_relu};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL strobes cyc=%0d actual=%h expected=%h", cyc, act, exp);
        end

        if (w_en_a) begin
            if (first_wen < 0) first_wen = cyc;
            last_wen = cyc;
        end
        if (valid_ac3) dut_ac3++;
        if (done) begin dut_done++; done_cyc = cyc; end
        if (proto_err) dut_perr++;
        if (out_valid && first_ov < 0) first_ov = cyc;

        while (q.size() > 0 && cyc - q[0].t >= PIPE_D) void'(q.pop_front());
        word_done = 0;
        if (rst) begin
            ms = IDLE;
            q.delete();
            {mk, mj, ml, mc, mo} = '0;
        end else begin
            case (ms)
                IDLE:  if (start) ms = CLEAR;
                CLEAR: begin ms = FEED; {mk, mj, ml, mc} = '0; end
                FEED: begin
                    if (perr) begin
                        ms = IDLE;
                        q.delete();
                    end else if (acc) begin
                        q.push_back('{cyc, mk, mj, ml, mc});
                        nacc++;
                        last = (mk == PA-1) && (mj == PW-1) && (ml == 3) && (mc == NCHUNK-1);
                        word_done = (mk == PA - 1);
                        mk++;
                        if (mk == PA) begin
                            mk = 0; mj++;
                            if (mj == PW) begin
                                mj = 0; ml++;
                                if (ml == NLANE) begin ml = 0; mc++; end
                            end
                        end
                        if (last) ms = DRAIN;
                    end
                end
                DRAIN: if (lastac3) begin ms = OUT; mo = 0; end
                OUT: begin
                    if (mo == 3) ms = IDLE;
                    mo++;
                end
                default: ms = IDLE;
            endcase
        end
    endtask

    task automatic step();
        #1 check_and_model();
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic run_job(input int gap, input int abort_word, input int rst_beat, output int t0);
        int g, budget;
        g = 0;
        budget = 0;
        nacc = 0; dut_ac3 = 0; dut_done = 0; dut_perr = 0;
        first_wen = -1; last_wen = -1; first_ov = -1; done_cyc = -1;
        t0 = cyc;
        while (1) begin
            start = (budget == 0) || (nacc == 50);
            rst = (rst_beat >= 0) && (nacc == rst_beat) && (ms == FEED);
            if (ms == FEED)
                in_valid = (g == 0) && !(abort_word >= 0 && nacc / PA == abort_word && mk == 3);
            else
                in_valid = (gap == 0);
            step();
            if (word_done) g = gap;
            else if (g > 0) g--;
            budget++;
            if (ms == IDLE) break;
            if (budget > 6000) begin
                errors++;
                $display("FAIL job_timeout cyc=%0d actual=%0d expected<=%0d", cyc, budget, 6000);
                break;
            end
        end
        start = 0;
        rst = 0;
        in_valid = 0;
    endtask

    vec_t tbl[11];

    initial begin
        int t0;
        tbl[0]  = '{1'b1, 1'b0, 1'b1, 8'b0000_0000};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'b0000_0000};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'b0000_0000};
        tbl[3]  = '{1'b0, 1'b1, 1'b1, 8'b0000_0000};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 8'b1001_0010};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 8'b1110_0000};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 8'b1110_1100};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 8'b1110_1010};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 8'b1110_1011};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'b0000_0000};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 8'b0000_0000};

        rst = 1; start = 0; in_valid = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);

        for (int i = 0; i < 11; i++) begin
            logic [7:0] act;
            rst = tbl[i].rst;
            start = tbl[i].start;
            in_valid = tbl[i].iv;
            #1;
            act = {busy, in_ready, w_en_a, cl_en_gen, w_en_br, MSB_a, cl_en_ac1, w_and_s_ac1};
            checks++;
            if (act !== tbl[i].exp) begin
                errors++;
                $display("FAIL vec%0d actual=%b expected=%b", i, act, tbl[i].exp);
            end
            @(posedge clk);
            cyc++;
            @(negedge clk);
        end
        rst = 0; start = 0; in_valid = 0;
        ms = IDLE; q.delete(); {mk, mj, ml, mc, mo} = '0;
        repeat (2) step();

        // back-to-back beats: exact job timing
        run_job(0, -1, -1, t0);
        chk("t2_beats", nacc, 2304);
        chk("t2_ac3_count", dut_ac3, 72);
        chk("t2_first_beat", first_wen - t0, 2);
        chk("t2_last_beat", last_wen - t0, 2305);
        chk("t2_first_out", first_ov - t0, 2311);
        chk("t2_done_cyc", done_cyc - t0, 2314);
        chk("t2_done_count", dut_done, 1);
        chk("t2_perr", dut_perr, 0);
        repeat (3) step();

        // 5-cycle gaps between words
        run_job(5, -1, -1, t0);
        chk("t3_beats", nacc, 2304);
        chk("t3_ac3_count", dut_ac3, 72);
        chk("t3_done_count", dut_done, 1);
        chk("t3_perr", dut_perr, 0);
        repeat (3) step();

        // in_valid dropped at k=3 of word 7, then a clean job
        run_job(0, 7, -1, t0);
        chk("t4_perr", dut_perr, 1);
        chk("t4_done", dut_done, 0);
        chk("t4_beats", nacc, 7 * PA + 3);
        repeat (3) step();
        run_job(0, -1, -1, t0);
        chk("t4_rerun_done", dut_done, 1);
        chk("t4_rerun_ac3", dut_ac3, 72);
        chk("t4_rerun_done_cyc", done_cyc - t0, 2314);
        repeat (3) step();

        // reset at beat 100, then a clean job
        run_job(0, -1, 100, t0);
        chk("t5_beats", nacc, 100);
        chk("t5_done", dut_done, 0);
        repeat (3) step();
        run_job(0, -1, -1, t0);
        chk("t5_rerun_done", dut_done, 1);
        chk("t5_rerun_ac3", dut_ac3, 72);
        chk("t5_rerun_beats", nacc, 2304);
        repeat (3) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
